// File: rtl/mem_link_arbiter.sv
// mem_link_arbiter
//   Shares one link channel between N = 1<<REQ_BIT CPU-side memory requesters.
//   A round-robin arbiter picks one pending request, packs it into a single
//   link message, then waits for the matching response (or a timeout) before
//   returning read data / error to the granted requester. One transaction is
//   outstanding at a time.
//
// Ports
//   CLK, RST                 clock (posedge), synchronous active-low reset
//   req_valid/write[N]       per-requester request strobe (held until ready) / rw
//   req_mask[4N]             per-requester byte enables (writes only)
//   req_addr/wdata[32N]      per-requester address / write data
//   req_ready[N]             one-cycle pulse: request sent on the link
//   resp_valid[N]            one-cycle pulse: transaction done for that requester
//   resp_err, resp_rdata     timeout/malformed flag and read data, with resp_valid
//   ch_writable              link write FIFO not full
//   ch_write_flag/data       push strobe and message {len[4:0], payload}
//   ch_readable, ch_read_data  link read FIFO not empty, FWFT head
//   ch_read_flag             pop strobe to link read FIFO

// Per-requester message packing: {length, payload} for one request.
module mem_link_req_pack #(
    parameter int MESSAGE_BIT = 72
) (
    input  logic                   write,
    input  logic [3:0]             mask,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [MESSAGE_BIT+4:0] msg
);
    always_comb begin
        msg = '0;
        msg[MESSAGE_BIT+4 -: 5] = write ? 5'd9 : 5'd5;
        // Reads carry no data or byte enables on the wire.
        msg[71:0] = {(write ? wdata : 32'h0), addr, 3'b000, write, (write ? mask : 4'h0)};
    end
endmodule

module mem_link_arbiter #(
    parameter int REQ_BIT     = 1,
    parameter int MESSAGE_BIT = 72,
    parameter int TIMEOUT     = 4095,
    localparam int N          = 1 << REQ_BIT,
    localparam int MW         = MESSAGE_BIT + 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_write,
    input  logic [4*N-1:0]  req_mask,
    input  logic [32*N-1:0] req_addr,
    input  logic [32*N-1:0] req_wdata,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic            resp_err,
    output logic [31:0]     resp_rdata,
    input  logic            ch_writable,
    output logic            ch_write_flag,
    output logic [MW-1:0]   ch_write_data,
    input  logic            ch_readable,
    input  logic [MW-1:0]   ch_read_data,
    output logic            ch_read_flag
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t               state;
    logic [REQ_BIT-1:0]   last_grant;
    logic [REQ_BIT-1:0]   cur_grant;
    logic                 cur_write;
    logic [15:0]          wait_cnt;

    logic [N-1:0][MW-1:0] msg_all;
    logic [REQ_BIT-1:0]   grant_idx;
    logic [REQ_BIT-1:0]   scan_idx;
    logic [4:0]           rsp_len;
    logic                 rsp_ok;
    logic [31:0]          rsp_rdata;
    logic                 pop_ok;
    logic                 rsp_unused;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        mem_link_req_pack #(.MESSAGE_BIT(MESSAGE_BIT)) u_pack (
            .write (req_write[gi]),
            .mask  (req_mask[4*gi +: 4]),
            .addr  (req_addr[32*gi +: 32]),
            .wdata (req_wdata[32*gi +: 32]),
            .msg   (msg_all[gi])
        );
    end

    // Round robin: scan from the farthest offset down so the closest
    // requester after last_grant is the one left standing.
    always_comb begin
        grant_idx = last_grant;
        scan_idx  = '0;
        for (int i = N; i >= 1; i--) begin
            scan_idx = last_grant + REQ_BIT'(i);
            if (req_valid[scan_idx]) grant_idx = scan_idx;
        end
    end

    // A pop issued last cycle has not reached the FIFO head yet; the flag
    // guard keeps the same word from being consumed twice.
    assign pop_ok = ch_readable && !ch_read_flag;

    assign rsp_len    = ch_read_data[MW-1 -: 5];
    assign rsp_ok     = cur_write ? (rsp_len == 5'd0) : (rsp_len == 5'd4);
    assign rsp_rdata  = (rsp_ok && !cur_write) ? ch_read_data[31:0] : 32'h0;
    assign rsp_unused = ^ch_read_data[MESSAGE_BIT-1:32];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= ST_IDLE;
            last_grant    <= '1;
            cur_grant     <= '0;
            cur_write     <= 1'b0;
            wait_cnt      <= '0;
            req_ready     <= '0;
            resp_valid    <= '0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            ch_write_flag <= 1'b0;
            ch_write_data <= '0;
            ch_read_flag  <= 1'b0;
        end else begin
            req_ready     <= '0;
            resp_valid    <= '0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            ch_write_flag <= 1'b0;
            ch_write_data <= '0;
            ch_read_flag  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_ok) begin
                        // Late response from an abandoned/timed-out request.
                        ch_read_flag <= 1'b1;
                    end else if (|req_valid && ch_writable) begin
                        ch_write_flag <= 1'b1;
                        ch_write_data <= msg_all[grant_idx];
                        req_ready     <= N'(1) << grant_idx;
                        cur_grant     <= grant_idx;
                        cur_write     <= req_write[grant_idx];
                        last_grant    <= grant_idx;
                        wait_cnt      <= '0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pop_ok) begin
                        ch_read_flag <= 1'b1;
                        resp_valid   <= N'(1) << cur_grant;
                        resp_err     <= !rsp_ok;
                        resp_rdata   <= rsp_rdata;
                        state        <= ST_IDLE;
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        resp_valid <= N'(1) << cur_grant;
                        resp_err   <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_link_arbiter.sv
// Bench for mem_link_arbiter: directed scenarios followed by a randomized
// phase, all checked cycle by cycle against a transaction-level model.
module tb_mem_link_arbiter;
    localparam int REQ_BIT = 1;
    localparam int N       = 2;
    localparam int MB      = 72;
    localparam int MW      = MB + 5;
    localparam int TO      = 8;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [4*N-1:0]  req_mask  = '0;
    logic [32*N-1:0] req_addr  = '0;
    logic [32*N-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic            resp_err;
    logic [31:0]     resp_rdata;
    logic            ch_writable = 1'b1;
    logic            ch_write_flag;
    logic [MW-1:0]   ch_write_data;
    logic            ch_readable = 1'b0;
    logic [MW-1:0]   ch_read_data = '0;
    logic            ch_read_flag;

    always #5 CLK = ~CLK;

    mem_link_arbiter #(.REQ_BIT(REQ_BIT), .MESSAGE_BIT(MB), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_write(req_write), .req_mask(req_mask),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ch_writable(ch_writable), .ch_write_flag(ch_write_flag),
        .ch_write_data(ch_write_data), .ch_readable(ch_readable),
        .ch_read_data(ch_read_data), .ch_read_flag(ch_read_flag)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // link environment: read FIFO and scheduled responses
    logic [MW-1:0] fifo[$];
    logic [MW-1:0] sch_msg[$];
    int            sch_due[$];
    logic          dut_rf_prev = 1'b0;

    // stimulus knobs
    bit            rand_mode = 0;
    bit            hold      = 0;
    int            dir_delay = -1;
    logic [4:0]    dir_len   = 5'd4;
    logic [31:0]   dir_pay   = '0;

    // observed events
    int            cyc = 0;
    int            wr_cnt = 0, rsp_cnt = 0, wr_cyc_obs = 0, rsp_cyc_obs = 0;
    logic [MW-1:0] last_wd = '0;
    logic [31:0]   last_rdata = '0;
    logic          last_err = 1'b0;
    logic [N-1:0]  last_rv = '0;
    int            grants[$];

    // reference model: outstanding transaction and round-robin pointer
    bit            m_busy = 0;
    int            m_g = 0;
    bit            m_w = 0;
    int            m_wr_cyc = 0;
    int            m_last = N - 1;
    bit            m_rf = 0;

    function automatic logic [MW-1:0] exp_msg(input int g);
        logic [MW-1:0] m;
        logic          w;
        w = req_write[g];
        m = '0;
        m[MW-1 -: 5] = w ? 5'd9 : 5'd5;
        m[71:40]     = w ? req_wdata[32*g +: 32] : 32'h0;
        m[39:8]      = req_addr[32*g +: 32];
        m[4]         = w;
        m[3:0]       = w ? req_mask[4*g +: 4] : 4'h0;
        return m;
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (req_valid[c]) return c;
        end
        return 0;
    endfunction

    task automatic new_req(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        req_valid[i]          = 1'b1;
        req_write[i]          = w;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        req_mask[4*i +: 4]    = m;
    endtask

    task automatic cycle();
        logic [MW-1:0] e_wd;
        logic [N-1:0]  e_ready, e_rv;
        logic          e_wf, e_rf, e_err;
        logic [31:0]   e_rdata;
        logic [4:0]    len;
        bit            ok;
        int            g;
        cyc++;
        e_wd = '0; e_ready = '0; e_rv = '0; e_wf = 0; e_rf = 0; e_err = 0; e_rdata = '0;
        // what the spec says must follow the edge that just happened
        if (!RST) begin
            m_busy = 0;
            m_last = N - 1;
        end else if (!m_busy) begin
            if (ch_readable && !m_rf) begin
                e_rf = 1;
            end else if (req_valid != '0 && ch_writable) begin
                g = rr_pick();
                e_wf = 1; e_wd = exp_msg(g); e_ready[g] = 1'b1;
                m_busy = 1; m_g = g; m_w = req_write[g]; m_last = g; m_wr_cyc = cyc;
            end
        end else begin
            if (ch_readable && !m_rf) begin
                len = ch_read_data[MW-1 -: 5];
                ok = m_w ? (len == 5'd0) : (len == 5'd4);
                e_rf = 1; e_rv[m_g] = 1'b1; e_err = !ok;
                e_rdata = (ok && !m_w) ? ch_read_data[31:0] : 32'h0;
                m_busy = 0;
            end else if (cyc - m_wr_cyc == TO) begin
                e_rv[m_g] = 1'b1; e_err = 1;
                m_busy = 0;
            end
        end
        m_rf = e_rf;
        // FIFO pops on the edge where the DUT's pop strobe was high
        if (dut_rf_prev && fifo.size() > 0) void'(fifo.pop_front());

        chk("wflag", 128'(ch_write_flag), 128'(e_wf));
        if (e_wf) chk("wdata", 128'(ch_write_data), 128'(e_wd));
        chk("ready", 128'(req_ready), 128'(e_ready));
        chk("rvalid", 128'(resp_valid), 128'(e_rv));
        chk("rerr", 128'(resp_err), 128'(e_err));
        if (e_rv != '0) chk("rdata", 128'(resp_rdata), 128'(e_rdata));
        chk("rflag", 128'(ch_read_flag), 128'(e_rf));
        if (!RST) begin
            chk("rst_wdata", 128'(ch_write_data), 128'(0));
            chk("rst_rdata", 128'(resp_rdata), 128'(0));
        end

        if (ch_write_flag) begin
            wr_cnt++;
            wr_cyc_obs = cyc;
            last_wd = ch_write_data;
            for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
            if (rand_mode) begin
                if ($urandom % 6 != 0) begin
                    logic [MW-1:0] r;
                    r[31:0]  = $urandom;
                    r[63:32] = $urandom;
                    r[71:64] = 8'($urandom);
                    if ($urandom % 4 == 0) r[MW-1 -: 5] = 5'($urandom);
                    else r[MW-1 -: 5] = ch_write_data[4] ? 5'd0 : 5'd4;
                    sch_due.push_back(cyc + int'($urandom_range(1, 12)));
                    sch_msg.push_back(r);
                end
            end else if (dir_delay >= 0) begin
                sch_due.push_back(cyc + dir_delay);
                sch_msg.push_back({dir_len, 40'h0, dir_pay});
            end
        end
        if (resp_valid != '0) begin
            rsp_cnt++;
            rsp_cyc_obs = cyc;
            last_rdata = resp_rdata;
            last_err = resp_err;
            last_rv = resp_valid;
        end
        dut_rf_prev = ch_read_flag;

        // requesters
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && !hold) req_valid[i] = 1'b0;
            if (rand_mode) begin
                if (!req_valid[i] && $urandom % 4 == 0)
                    new_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
                else if (req_valid[i] && !req_ready[i] && $urandom % 40 == 0)
                    req_valid[i] = 1'b0;
            end
        end
        // deliver due responses
        for (int k = sch_due.size() - 1; k >= 0; k--) begin
            if (sch_due[k] <= cyc) begin
                fifo.push_back(sch_msg[k]);
                sch_due.delete(k);
                sch_msg.delete(k);
            end
        end
        if (rand_mode) ch_writable = ($urandom % 4) != 0;
        ch_readable  = fifo.size() > 0;
        ch_read_data = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic step();
        @(negedge CLK);
        cycle();
    endtask

    task automatic wait_resp(input int bound);
        int start;
        start = rsp_cnt;
        for (int k = 0; k < bound && rsp_cnt == start; k++) step();
        if (rsp_cnt == start) chk("resp_wait_bound", 128'(rsp_cnt - start), 128'(1));
    endtask

    initial begin
        int c0, raise;
        repeat (3) step();
        RST = 1'b1;

        // single read
        dir_delay = 3; dir_len = 5'd4; dir_pay = 32'hDEADBEEF;
        new_req(0, 0, 32'h1000, 32'hAAAA5555, 4'hF);
        wait_resp(40);
        chk("rd_len", 128'(last_wd[MW-1 -: 5]), 128'(5));
        chk("rd_addr", 128'(last_wd[39:8]), 128'(32'h1000));
        chk("rd_rdata", 128'(last_rdata), 128'(32'hDEADBEEF));
        chk("rd_err", 128'(last_err), 128'(0));
        chk("rd_who", 128'(last_rv), 128'(1));

        // write from requester 1
        dir_len = 5'd0;
        new_req(1, 1, 32'h20, 32'h12345678, 4'b0011);
        wait_resp(40);
        chk("wr_len", 128'(last_wd[MW-1 -: 5]), 128'(9));
        chk("wr_ctl", 128'(last_wd[7:0]), 128'(8'h13));
        chk("wr_wdata", 128'(last_wd[71:40]), 128'(32'h12345678));
        chk("wr_err", 128'(last_err), 128'(0));
        chk("wr_who", 128'(last_rv), 128'(2));

        // round robin with both held
        grants.delete();
        hold = 1; dir_len = 5'd4; dir_pay = 32'h0BADF00D; dir_delay = 2;
        new_req(0, 0, 32'h100, 0, 0);
        new_req(1, 0, 32'h200, 0, 0);
        repeat (4) wait_resp(40);
        hold = 0; req_valid = '0;
        chk("rr_n", 128'(grants.size()), 128'(4));
        for (int k = 0; k < grants.size() && k < 4; k++)
            chk($sformatf("rr_order%0d", k), 128'(grants[k]), 128'(k % 2));
        step();

        // backpressure
        ch_writable = 1'b0;
        new_req(0, 0, 32'h300, 0, 0);
        c0 = wr_cnt;
        repeat (10) step();
        chk("bp_no_write", 128'(wr_cnt - c0), 128'(0));
        ch_writable = 1'b1;
        raise = cyc;
        wait_resp(40);
        chk("bp_grant_cyc", 128'(wr_cyc_obs - raise), 128'(1));

        // timeout, then a late response drained in IDLE
        dir_delay = -1;
        new_req(0, 0, 32'h400, 0, 0);
        wait_resp(40);
        chk("to_latency", 128'(rsp_cyc_obs - wr_cyc_obs), 128'(TO));
        chk("to_err", 128'(last_err), 128'(1));
        chk("to_rdata", 128'(last_rdata), 128'(0));
        c0 = rsp_cnt;
        sch_due.push_back(cyc + 1);
        sch_msg.push_back({5'd4, 40'h0, 32'h55AA55AA});
        repeat (5) step();
        chk("late_drained", 128'(fifo.size()), 128'(0));
        chk("late_no_resp", 128'(rsp_cnt - c0), 128'(0));
        dir_delay = 2; dir_len = 5'd4; dir_pay = 32'hCAFEF00D;
        new_req(1, 0, 32'h500, 0, 0);
        wait_resp(40);
        chk("post_to_rdata", 128'(last_rdata), 128'(32'hCAFEF00D));
        chk("post_to_err", 128'(last_err), 128'(0));

        // malformed response
        dir_len = 5'd7;
        new_req(0, 0, 32'h600, 0, 0);
        wait_resp(40);
        chk("bad_len_err", 128'(last_err), 128'(1));
        chk("bad_len_rdata", 128'(last_rdata), 128'(0));

        // reset in the middle of WAIT
        dir_delay = -1;
        new_req(1, 1, 32'h700, 32'h1, 4'h1);
        c0 = wr_cnt;
        for (int k = 0; k < 20 && wr_cnt == c0; k++) step();
        chk("rst_granted", 128'(wr_cnt - c0), 128'(1));
        repeat (3) step();
        RST = 1'b0;
        c0 = rsp_cnt;
        repeat (2) step();
        RST = 1'b1;
        repeat (20) step();
        chk("rst_abandoned", 128'(rsp_cnt - c0), 128'(0));

        // randomized traffic
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        req_valid = '0;
        ch_writable = 1'b1;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
